// File: rtl/seq_pkg.sv
// Shared types and constants for the program run sequencer.
package seq_pkg;

    localparam int PC_W = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    // Entry address of each program, indexed by program number.
    localparam logic [PC_W-1:0] PROG_BASE [4] = '{10'd0, 10'd256, 10'd512, 10'd768};

endpackage

// File: rtl/prog_sequencer_if.sv
// Bench/fetch-side signal bundle of the program sequencer.
interface prog_sequencer_if
    import seq_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic             Req;
    logic             Halt;
    logic             FetchLoad;
    logic             FetchHold;
    logic [PC_W-1:0]  StartAddr;
    logic [1:0]       ProgNum;
    logic             Done;
    logic [CNT_W-1:0] CycleCount;

    modport master (
        output Req, Halt,
        input  FetchLoad, FetchHold, StartAddr, ProgNum, Done, CycleCount
    );

    modport slave (
        input  Req, Halt,
        output FetchLoad, FetchHold, StartAddr, ProgNum, Done, CycleCount
    );
endinterface

// File: rtl/prog_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear, or increment unless already at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/prog_sequencer.sv
// Program run sequencer: arms on Req, launches on Req release, runs until Halt.
//
// state | meaning
// IDLE  | after reset, waiting for the first Req
// ARMED | Req seen, waiting for its release
// LOAD  | one cycle: fetch stage loads StartAddr
// RUN   | program executing, fetch free-running, cycles counted
// DONE  | run finished, count held, waiting for next Req
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_PROGS = 3,
    parameter int CNT_W     = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    prog_sequencer_if.slave bus
);
    localparam logic [1:0] LAST_PROG = 2'(NUM_PROGS - 1);

    seq_state_t state_q;
    seq_state_t state_d;
    logic [1:0] prog_num_q;
    logic [1:0] prog_num_d;
    logic       fetch_load;
    logic       fetch_hold;
    logic       done;
    logic       cnt_clr;
    logic       cnt_inc;

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Halt only matters in RUN, Req is ignored in LOAD/RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.Req)  state_d = S_ARMED;
            S_ARMED: if (!bus.Req) state_d = S_LOAD;
            S_LOAD:  state_d = S_RUN;
            S_RUN:   if (bus.Halt) state_d = S_DONE;
            S_DONE:  if (bus.Req)  state_d = S_ARMED;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        fetch_load = 1'b0;
        fetch_hold = 1'b1;
        done       = 1'b0;
        case (state_q)
            S_LOAD:  fetch_load = 1'b1;
            S_RUN:   fetch_hold = 1'b0;
            S_DONE:  done       = 1'b1;
            default: ;
        endcase
    end

    // Program index steps only when a new run is armed out of DONE.
    always_comb begin
        prog_num_d = prog_num_q;
        if ((state_q == S_DONE) && bus.Req) begin
            prog_num_d = (prog_num_q == LAST_PROG) ? 2'd0 : prog_num_q + 2'd1;
        end
    end

    // Program index register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            prog_num_q <= 2'd0;
        end else begin
            prog_num_q <= prog_num_d;
        end
    end

    // Count restarts as LOAD is entered so LOAD itself reads zero.
    assign cnt_clr = (state_q == S_ARMED) && !bus.Req;
    assign cnt_inc = (state_q == S_RUN);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .cnt   (bus.CycleCount)
    );

    assign bus.FetchLoad = fetch_load;
    assign bus.FetchHold = fetch_hold;
    assign bus.Done      = done;
    assign bus.ProgNum   = prog_num_q;
    assign bus.StartAddr = PROG_BASE[prog_num_q];
endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: vector table plus a saturation sequence.
module tb_prog_sequencer;
    import seq_pkg::*;

    typedef struct {
        logic        rst;
        logic        req;
        logic        halt;
        logic        fl;
        logic        fh;
        logic [9:0]  sa;
        logic [1:0]  pn;
        logic        done;
        logic [15:0] cc;
    } vec_t;

    logic Clk;
    logic rst;
    logic rst4;
    int   n_checks;
    int   n_pass;
    vec_t vecs[$];

    prog_sequencer_if #(.CNT_W(16)) bus  ();
    prog_sequencer_if #(.CNT_W(4))  bus4 ();

    prog_sequencer #(.NUM_PROGS(3), .CNT_W(16)) dut (
        .Clk   (Clk),
        .Reset (rst),
        .bus   (bus)
    );

    prog_sequencer #(.NUM_PROGS(3), .CNT_W(4)) dut4 (
        .Clk   (Clk),
        .Reset (rst4),
        .bus   (bus4)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic vec_t mk(input logic r, input logic q, input logic h,
                                input logic fl, input logic fh, input int sa,
                                input int pn, input logic d, input int cc);
        vec_t v;
        v.rst = r; v.req = q; v.halt = h;
        v.fl = fl; v.fh = fh; v.sa = 10'(sa); v.pn = 2'(pn);
        v.done = d; v.cc = 16'(cc);
        return v;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst  = 1'b1; rst4 = 1'b1;
        bus.Req  = 1'b0; bus.Halt  = 1'b0;
        bus4.Req = 1'b0; bus4.Halt = 1'b0;

        //           rst req halt | FL FH  SA  PN Done CC
        vecs.push_back(mk(1, 0, 0,  0, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  0, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  0, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0,  0, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  1, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0,  0, 0,   0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 3));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 4));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 5));
        vecs.push_back(mk(0, 0, 1,  0, 1,   0, 0, 1, 6));
        vecs.push_back(mk(0, 0, 0,  0, 1,   0, 0, 1, 6));
        vecs.push_back(mk(0, 1, 0,  0, 1, 256, 1, 0, 6));
        vecs.push_back(mk(0, 0, 0,  1, 1, 256, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 256, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1,  0, 1, 256, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0,  0, 1, 256, 1, 1, 1));
        vecs.push_back(mk(0, 1, 0,  0, 1, 512, 2, 0, 1));
        vecs.push_back(mk(0, 0, 0,  1, 1, 512, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 512, 2, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 512, 2, 0, 1));
        vecs.push_back(mk(0, 0, 1,  0, 1, 512, 2, 1, 2));
        vecs.push_back(mk(0, 1, 0,  0, 1,   0, 0, 0, 2));
        vecs.push_back(mk(0, 0, 0,  1, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0,   0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1,  0, 1,   0, 0, 1, 2));
        vecs.push_back(mk(0, 1, 0,  0, 1, 256, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0,  1, 1, 256, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 256, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 256, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0,  0, 0, 256, 1, 0, 2));
        vecs.push_back(mk(0, 0, 0,  0, 0, 256, 1, 0, 3));
        vecs.push_back(mk(1, 1, 1,  0, 1,   0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 1,   0, 0, 0, 0));

        foreach (vecs[i]) begin
            rst      = vecs[i].rst;
            bus.Req  = vecs[i].req;
            bus.Halt = vecs[i].halt;
            step();
            check("FetchLoad",  i, int'(bus.FetchLoad),  int'(vecs[i].fl));
            check("FetchHold",  i, int'(bus.FetchHold),  int'(vecs[i].fh));
            check("StartAddr",  i, int'(bus.StartAddr),  int'(vecs[i].sa));
            check("ProgNum",    i, int'(bus.ProgNum),    int'(vecs[i].pn));
            check("Done",       i, int'(bus.Done),       int'(vecs[i].done));
            check("CycleCount", i, int'(bus.CycleCount), int'(vecs[i].cc));
        end

        // Saturation with a 4-bit counter: 20 RUN cycles, then halt and hold.
        rst4 = 1'b1;
        step();
        rst4 = 1'b0;
        bus4.Req = 1'b1;
        step();
        bus4.Req = 1'b0;
        step();
        check("sat LOAD FetchLoad", 0, int'(bus4.FetchLoad), 1);
        check("sat LOAD CycleCount", 0, int'(bus4.CycleCount), 0);
        for (int k = 0; k < 20; k++) begin
            step();
            check("sat RUN FetchHold", k, int'(bus4.FetchHold), 0);
            check("sat RUN CycleCount", k, int'(bus4.CycleCount), (k > 15) ? 15 : k);
        end
        bus4.Halt = 1'b1;
        step();
        bus4.Halt = 1'b0;
        check("sat DONE Done", 0, int'(bus4.Done), 1);
        check("sat DONE CycleCount", 0, int'(bus4.CycleCount), 15);
        step();
        check("sat hold CycleCount", 0, int'(bus4.CycleCount), 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PROGS, default 3: number of programs in the run series, range 1..4.
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the run-cycle counter.
REQ-003 The block SHALL have port Clk, input, 1: the single clock; all state changes on posedge only.
REQ-004 The block SHALL have port Reset, input, 1: synchronous, active-high reset.
REQ-005 The block SHALL have port Req, input, 1: level start request from the bench; a run commences when Req is released.
REQ-006 The block SHALL have port Halt, input, 1: halt opcode decoded in the current cycle.
REQ-007 The block SHALL have port FetchLoad, output, 1: one-cycle command for the fetch stage to load StartAddr into its PC.
REQ-008 The block SHALL have port FetchHold, output, 1: fetch stage holds its PC while this is high.
REQ-009 The block SHALL have port StartAddr, output, 10: entry address of the current program.
REQ-010 The block SHALL have port ProgNum, output, 2: index of the current or next program.
REQ-011 The block SHALL have port Done, output, 1: the last run has finished.
REQ-012 The block SHALL have port CycleCount, output, CNT_W: number of cycles spent in RUN during the last or current run.

Function
REQ-013 The FSM SHALL have the states IDLE, ARMED, LOAD, RUN and DONE.
REQ-014 IDLE: if Req=1, the FSM SHALL go to ARMED; otherwise it SHALL stay in IDLE.
REQ-015 ARMED: while Req=1 the FSM SHALL stay in ARMED; on Req=0 it SHALL go to LOAD.
REQ-016 LOAD SHALL last exactly 1 cycle and SHALL then go to RUN; Halt SHALL be ignored in LOAD.
REQ-017 RUN: if Halt=1, the FSM SHALL go to DONE; otherwise it SHALL stay in RUN; Req SHALL be ignored in RUN.
REQ-018 DONE: if Req=1, the FSM SHALL go to ARMED; otherwise it SHALL stay in DONE.
REQ-019 FetchHold SHALL be 1 in IDLE, ARMED, LOAD and DONE, and 0 only in RUN.
REQ-020 FetchLoad SHALL be 1 only in LOAD, as a Moore output.
REQ-021 StartAddr SHALL equal PROG_BASE[ProgNum] combinationally from the package table.
REQ-022 CycleCount SHALL clear to 0 on entry to LOAD.
REQ-023 CycleCount SHALL increment by 1 for each cycle in RUN, including the cycle in which Halt is sampled.
REQ-024 CycleCount SHALL saturate at all-ones with no wrap, and SHALL hold its value in DONE and ARMED.
REQ-025 Done SHALL be 1 in DONE and 0 in every other state; it SHALL drop in the cycle after Req is sampled high in DONE.
REQ-026 ProgNum SHALL advance on the DONE to ARMED transition only.
REQ-027 ProgNum SHALL wrap from NUM_PROGS-1 to 0.
REQ-028 If Req and Halt are both high in RUN, Halt SHALL take effect; Req SHALL be serviced only if it is still high in DONE.

Reset
REQ-029 Reset SHALL take priority over all other inputs in every state.
REQ-030 Reset SHALL force state IDLE, ProgNum=0, CycleCount=0, Done=0, FetchLoad=0 and FetchHold=1 on the next edge.
REQ-031 Reset asserted mid-RUN SHALL abort the run without passing through DONE.

Structure
REQ-032 Package seq_pkg SHALL hold the state enum seq_state_t, the PC width constant PC_W=10, and the table PROG_BASE = {10'd0, 10'd256, 10'd512, 10'd768}.
REQ-033 The saturating counter SHALL be the sub-module sat_counter, with ports Clk, Reset, clr, inc and cnt, and parameter W.
REQ-034 The FSM and ProgNum register SHALL stay in prog_sequencer.

Verification
REQ-035 Reset, then Req high for 3 cycles and then low -> ARMED for 3 cycles, FetchLoad pulses for 1 cycle with StartAddr=0, then RUN with FetchHold=0.
REQ-036 Halt pulsed after 5 RUN cycles -> CycleCount=6 and Done=1 are held; a new Req gives ProgNum=1, StartAddr=256 and Done=0 one cycle after Req.
REQ-037 Three full runs with NUM_PROGS=3 -> ProgNum follows 0,1,2,0 and StartAddr follows 0,256,512,0.
REQ-038 Reset asserted in the 4th RUN cycle -> next cycle shows IDLE, FetchHold=1, ProgNum=0, CycleCount=0 and no Done pulse.
REQ-039 Halt asserted during LOAD -> ignored, RUN is entered; Req pulsed in RUN -> ignored, no reload.
REQ-040 CNT_W=4 with RUN held for 20 cycles -> CycleCount saturates at 15 and holds.
